ddr_test_axil_master: RTL and testbench

AXI4-Lite initiator that turns single-beat register commands into AXI-Lite write or read transactions. It sits between the DDR test sequencer/debug controller and the DDR test register slave, and issues accesses to the 10-bit, 64-bit register map (version, REQ_LEN, test_mode, prbs start/sel, counters). Exactly one transaction is outstanding at a time, and a per-transaction timeout guards against a hung slave.

---
 rtl/ddr_test_axil_master.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_ddr_test_axil_master.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_test_axil_master.sv
// AXI4-Lite initiator with one transaction in flight: cmd -> AW+W/B or AR/R -> rsp, 5-cycle minimum spacing, per-transaction timeout.
// Holds cmd_ready low until the response is consumed; optional counters under DDR_TEST_AXIL_MST_STATS_EN.
module ddr_test_axil_master #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    m_axi_aclk,
    input  logic                    m_axi_areset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_wr,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    output logic                    busy
`ifdef DDR_TEST_AXIL_MST_STATS_EN
    ,
    output logic [31:0]             wr_txn_cnt,
    output logic [31:0]             rd_txn_cnt,
    output logic [15:0]             err_cnt
`endif
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CW     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    busy_q, busy_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic [CW-1:0]           tmo_cnt_q, tmo_cnt_d;
    logic                    expire;
    logic                    take_tmo;
    logic                    aw_done, w_done;

    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        tmo_cnt_d     = tmo_cnt_q;
        expire        = 1'b0;
        take_tmo      = 1'b0;
        aw_done       = 1'b0;
        w_done        = 1'b0;

        // Saturating counter; expiry is the cycle in which it reaches the limit.
        if (TIMEOUT_CYCLES != 0 && state_q != IDLE && state_q != RSP) begin
            if (tmo_cnt_q != TMO) begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
            expire = (tmo_cnt_d == TMO);
        end

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
                    cmd_ready_d = 1'b0;
                    tmo_cnt_d   = '0;
                    if (cmd_wr) begin
                        state_d   = WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR: begin
                aw_done = !awvalid_q || m_axi_awready;
                w_done  = !wvalid_q || m_axi_wready;
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end else if (expire) begin
                    take_tmo = 1'b1;
                end
            end
            WR_RESP: begin
                if (m_axi_bvalid) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = m_axi_bresp;
                    rsp_timeout_d = 1'b0;
                    state_d       = RSP;
                end else if (expire) begin
                    take_tmo = 1'b1;
                end
            end
            RD_ADDR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end else if (expire) begin
                    take_tmo = 1'b1;
                end
            end
            RD_DATA: begin
                if (m_axi_rvalid) begin
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = m_axi_rdata;
                    rsp_resp_d    = m_axi_rresp;
                    rsp_timeout_d = 1'b0;
                    state_d       = RSP;
                end else if (expire) begin
                    take_tmo = 1'b1;
                end
            end
            RSP: begin
                // cmd_ready stays low for one IDLE cycle after the response is taken.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (take_tmo) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_resp_d    = 2'b10;
            rsp_timeout_d = 1'b1;
            state_d       = RSP;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
            tmo_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign busy          = busy_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

`ifdef DDR_TEST_AXIL_MST_STATS_EN
    logic        is_wr_q, is_wr_d;
    logic [31:0] wr_txn_cnt_q, wr_txn_cnt_d;
    logic [31:0] rd_txn_cnt_q, rd_txn_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        rsp_hs;

    always_comb begin
        rsp_hs       = rsp_valid_q && rsp_ready;
        is_wr_d      = is_wr_q;
        wr_txn_cnt_d = wr_txn_cnt_q;
        rd_txn_cnt_d = rd_txn_cnt_q;
        err_cnt_d    = err_cnt_q;
        if (state_q == IDLE && cmd_valid && cmd_ready_q) begin
            is_wr_d = cmd_wr;
        end
        if (rsp_hs) begin
            if (is_wr_q) wr_txn_cnt_d = wr_txn_cnt_q + 32'd1;
            else         rd_txn_cnt_d = rd_txn_cnt_q + 32'd1;
            if (rsp_resp_q != 2'b00 && err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            is_wr_q      <= 1'b0;
            wr_txn_cnt_q <= '0;
            rd_txn_cnt_q <= '0;
            err_cnt_q    <= '0;
        end else begin
            is_wr_q      <= is_wr_d;
            wr_txn_cnt_q <= wr_txn_cnt_d;
            rd_txn_cnt_q <= rd_txn_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign wr_txn_cnt = wr_txn_cnt_q;
    assign rd_txn_cnt = rd_txn_cnt_q;
    assign err_cnt    = err_cnt_q;
`endif

endmodule

// File: tb/tb_ddr_test_axil_master.sv
// Randomized bench: reactive AXI-Lite slave with a memory, reference memory and timeout rule for expected responses.
module tb_ddr_test_axil_master;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        areset;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [9:0]  cmd_addr;
    logic [63:0] cmd_wdata;
    logic [7:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [63:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic [9:0]  m_axi_awaddr, m_axi_araddr;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [63:0] m_axi_wdata, m_axi_rdata;
    logic [7:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;
    logic        busy;
`ifdef DDR_TEST_AXIL_MST_STATS_EN
    logic [31:0] wr_txn_cnt, rd_txn_cnt;
    logic [15:0] err_cnt;
    int          exp_wr_cnt = 0, exp_rd_cnt = 0, exp_err_cnt = 0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] slave_mem [128];
    logic [63:0] ref_mem   [128];

    ddr_test_axil_master #(
        .ADDR_WIDTH(10), .DATA_WIDTH(64), .TIMEOUT_CYCLES(T)
    ) dut (
        .m_axi_aclk(clk), .m_axi_areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .busy(busy)
`ifdef DDR_TEST_AXIL_MST_STATS_EN
        , .wr_txn_cnt(wr_txn_cnt), .rd_txn_cnt(rd_txn_cnt), .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Phase 1 (address/data) completes at active cycle d1+1, phase 2 d2 cycles later.
    // The limit hits at active cycle T unless that cycle's handshake advances the phase.
    function automatic bit ref_normal(input int d1, input int d2);
        int k1, k2;
        k1 = d1 + 1;
        k2 = k1 + 1 + d2;
        return (k1 <= T) && (d2 == 0 || k2 <= T);
    endfunction

    function automatic int min_t(input int v);
        return (v < T) ? v : T;
    endfunction

    task automatic slave_idle();
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;    m_axi_rresp = 2'b00;
    endtask

    task automatic run_txn(input bit wr, input logic [9:0] a, input logic [63:0] wd,
                           input logic [7:0] st, input int d1a, input int d1w, input int d2,
                           input logic [1:0] sresp, input int hold);
        int k, guard, ph1_k, hold_cnt, d1;
        int aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_cyc, w_cyc, ar_cyc;
        int bad_hold, bad_rdy, unstable, bad_cmd;
        bit done, seen, normal, exp_a, exp_w, cap_tmo;
        logic [63:0] exp_rdata, cap_rdata, rd_val;
        logic [1:0]  exp_resp, cap_resp;
        logic [9:0]  aw_seen;
        logic [63:0] w_seen;
        logic [7:0]  s_seen;

        k = 0; guard = 0; ph1_k = 0; hold_cnt = 0;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; aw_cyc = 0; w_cyc = 0; ar_cyc = 0;
        bad_hold = 0; bad_rdy = 0; unstable = 0; bad_cmd = 0;
        done = 0; seen = 0; cap_tmo = 0; cap_rdata = '0; cap_resp = '0; rd_val = '0;
        aw_seen = '0; w_seen = '0; s_seen = '0;

        d1     = (wr && d1w > d1a) ? d1w : d1a;
        normal = ref_normal(d1, d2);
        exp_a  = (d1a + 1 <= T);
        exp_w  = wr && (d1w + 1 <= T);
        if (wr && exp_a && exp_w) begin
            for (int b = 0; b < 8; b++) if (st[b]) ref_mem[a[9:3]][b*8 +: 8] = wd[b*8 +: 8];
        end
        exp_rdata = (!wr && normal) ? ref_mem[a[9:3]] : 64'd0;
        exp_resp  = normal ? sresp : 2'b10;

        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("cmd_ready_wait", 64'(guard < 50), 64'd1);
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = wd; cmd_wstrb = st;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_addr = ~a; cmd_wdata = ~wd; cmd_wstrb = ~st;
        k = 1;

        while (!done && k < 200) begin
            if (wr) begin
                m_axi_awready = m_axi_awvalid && (k > d1a);
                m_axi_wready  = m_axi_wvalid && (k > d1w);
                if (m_axi_awvalid) begin
                    aw_cyc++;
                    if (m_axi_awaddr !== a) bad_hold++;
                end
                if (m_axi_wvalid) begin
                    w_cyc++;
                    if (m_axi_wdata !== wd || m_axi_wstrb !== st) bad_hold++;
                end
                if (m_axi_awvalid && m_axi_awready) begin aw_hs++; aw_seen = m_axi_awaddr; end
                if (m_axi_wvalid && m_axi_wready) begin w_hs++; w_seen = m_axi_wdata; s_seen = m_axi_wstrb; end
                if (aw_hs > 0 && w_hs > 0 && ph1_k == 0) begin
                    ph1_k = k;
                    for (int b = 0; b < 8; b++)
                        if (s_seen[b]) slave_mem[aw_seen[9:3]][b*8 +: 8] = w_seen[b*8 +: 8];
                end
                m_axi_bvalid = (ph1_k != 0) && (k > ph1_k + d2) && (b_hs == 0);
                m_axi_bresp  = sresp;
                if (m_axi_bvalid && m_axi_bready) b_hs++;
                if (m_axi_bready && (ph1_k == 0 || k <= ph1_k)) bad_rdy++;
            end else begin
                m_axi_arready = m_axi_arvalid && (k > d1a);
                if (m_axi_arvalid) begin
                    ar_cyc++;
                    if (m_axi_araddr !== a) bad_hold++;
                end
                if (m_axi_arvalid && m_axi_arready) begin
                    ar_hs++;
                    ph1_k  = k;
                    rd_val = slave_mem[m_axi_araddr[9:3]];
                end
                m_axi_rvalid = (ph1_k != 0) && (k > ph1_k + d2) && (r_hs == 0);
                m_axi_rdata  = m_axi_rvalid ? rd_val : 64'hDEAD_BEEF_0BAD_F00D;
                m_axi_rresp  = sresp;
                if (m_axi_rvalid && m_axi_rready) r_hs++;
                if (m_axi_rready && (ph1_k == 0 || k <= ph1_k)) bad_rdy++;
            end

            if (rsp_valid) begin
                if (!seen) begin
                    seen = 1; cap_rdata = rsp_rdata; cap_resp = rsp_resp; cap_tmo = rsp_timeout;
                end else if (rsp_rdata !== cap_rdata || rsp_resp !== cap_resp || rsp_timeout !== cap_tmo) begin
                    unstable++;
                end
                if (cmd_ready) bad_cmd++;
                rsp_ready = (hold_cnt >= hold);
                cmd_valid = (hold > 0) && !rsp_ready;
                hold_cnt++;
                if (rsp_ready) done = 1;
            end
            @(negedge clk);
            k++;
        end

        chk("rsp_seen", 64'(done), 64'd1);
        chk("rsp_rdata", cap_rdata, exp_rdata);
        chk("rsp_resp", 64'(cap_resp), 64'(exp_resp));
        chk("rsp_timeout", 64'(cap_tmo), 64'(!normal));
        if (wr) begin
            chk("aw_hs", 64'(aw_hs), 64'(exp_a));
            chk("w_hs", 64'(w_hs), 64'(exp_w));
            chk("b_hs", 64'(b_hs), 64'(normal));
            chk("aw_cycles", 64'(aw_cyc), 64'(min_t(d1a + 1)));
            chk("w_cycles", 64'(w_cyc), 64'(min_t(d1w + 1)));
        end else begin
            chk("ar_hs", 64'(ar_hs), 64'(exp_a));
            chk("r_hs", 64'(r_hs), 64'(normal));
            chk("ar_cycles", 64'(ar_cyc), 64'(min_t(d1a + 1)));
        end
        chk("addr_data_stable", 64'(bad_hold), 64'd0);
        chk("resp_ready_window", 64'(bad_rdy), 64'd0);
        chk("rsp_stable", 64'(unstable), 64'd0);
        chk("cmd_ready_in_rsp", 64'(bad_cmd), 64'd0);
        chk("post_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("post_busy", 64'(busy), 64'd0);
        chk("post_cmd_ready_lo", 64'(cmd_ready), 64'd0);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        slave_idle();
        @(negedge clk);
        chk("post_cmd_ready_hi", 64'(cmd_ready), 64'd1);
`ifdef DDR_TEST_AXIL_MST_STATS_EN
        if (wr) exp_wr_cnt++;
        else    exp_rd_cnt++;
        if (exp_resp != 2'b00) exp_err_cnt++;
        chk("wr_txn_cnt", 64'(wr_txn_cnt), 64'(exp_wr_cnt));
        chk("rd_txn_cnt", 64'(rd_txn_cnt), 64'(exp_rd_cnt));
        chk("err_cnt", 64'(err_cnt), 64'(exp_err_cnt));
`endif
    endtask

    task automatic reset_mid_write();
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 10'h30; cmd_wdata = 64'h1234; cmd_wstrb = 8'hFF;
        @(negedge clk);
        cmd_valid = 1'b0;
        slave_idle();
        @(negedge clk);
        chk("rst_pre_awvalid", 64'(m_axi_awvalid), 64'd1);
        chk("rst_pre_wvalid", 64'(m_axi_wvalid), 64'd1);
        areset = 1'b1;
        @(negedge clk);
        areset = 1'b0;
        chk("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
        chk("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
`ifdef DDR_TEST_AXIL_MST_STATS_EN
        exp_wr_cnt = 0; exp_rd_cnt = 0; exp_err_cnt = 0;
        chk("rst_counters", 64'({wr_txn_cnt, rd_txn_cnt} | 64'(err_cnt)), 64'd0);
`endif
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] v;
        bit          wr;
        int          da, dw, db, hold;
        areset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_wstrb = '0; rsp_ready = 1'b0;
        slave_idle();
        for (int i = 0; i < 128; i++) begin
            v = {$urandom, $urandom};
            slave_mem[i] = v;
            ref_mem[i]   = v;
        end
        slave_mem[0] = 64'hF50010;
        ref_mem[0]   = 64'hF50010;
        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("reset_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, rsp_valid}), 64'd0);
        chk("reset_readies", 64'({m_axi_bready, m_axi_rready, busy}), 64'd0);
        chk("reset_data", m_axi_awaddr | m_axi_wdata | rsp_rdata | 64'(rsp_resp) | 64'(rsp_timeout), 64'd0);
        chk("prot", 64'({m_axi_awprot, m_axi_arprot}), 64'd0);
        areset = 1'b0;
        @(negedge clk);

        run_txn(1, 10'h18, 64'h5,      8'hFF, 0, 0, 0, 2'b00, 0);
        run_txn(1, 10'h10, 64'h400000, 8'hFF, 0, 3, 1, 2'b00, 0);
        run_txn(0, 10'h00, 64'h0,      8'h00, 0, 0, 2, 2'b00, 0);
        run_txn(0, 10'h18, 64'h0,      8'h00, 1, 0, 0, 2'b00, 10);
        run_txn(0, 10'h08, 64'h0,      8'h00, 100, 0, 0, 2'b00, 1);
        run_txn(0, 10'h10, 64'h0,      8'h00, 0, 0, 0, 2'b00, 0);
        run_txn(0, 10'h20, 64'h0,      8'h00, 7, 0, 7, 2'b00, 0);
        run_txn(0, 10'h20, 64'h0,      8'h00, 7, 0, 8, 2'b00, 0);
        run_txn(0, 10'h28, 64'h0,      8'h00, 15, 0, 0, 2'b01, 0);
        run_txn(0, 10'h28, 64'h0,      8'h00, 0, 0, 16, 2'b00, 3);
        run_txn(1, 10'h38, 64'hA5A5_5A5A_0F0F_F0F0, 8'h3C, 15, 0, 0, 2'b00, 0);
        run_txn(1, 10'h40, 64'h1111,   8'hFF, 2, 16, 0, 2'b00, 0);
        run_txn(1, 10'h48, 64'h2222,   8'h0F, 0, 0, 0, 2'b10, 0);
        run_txn(1, 10'h50, 64'h3333,   8'hF0, 1, 1, 1, 2'b11, 2);
        run_txn(0, 10'h38, 64'h0,      8'h00, 0, 0, 0, 2'b00, 0);
        run_txn(0, 10'h40, 64'h0,      8'h00, 0, 0, 0, 2'b00, 0);
        reset_mid_write();
        run_txn(0, 10'h18, 64'h0,      8'h00, 0, 0, 0, 2'b00, 0);

        for (int i = 0; i < 60; i++) begin
            wr   = bit'($urandom_range(0, 1));
            da   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 4));
            dw   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 4));
            db   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(6, 20))  : int'($urandom_range(0, 4));
            hold = int'($urandom_range(0, 3));
            run_txn(wr, {7'($urandom_range(0, 127)), 3'b000}, {$urandom, $urandom},
                    8'($urandom), da, dw, db, 2'($urandom_range(0, 3)), hold);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
